// File: rtl/cybercobra_ctrl_pkg.sv
// Shared types and constants for the CYBERcobra execution sequencer.
package cybercobra_ctrl_pkg;

    localparam int unsigned RATE_SEL_W = 4;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        BREAK = 2'd2
    } run_state_t;

endpackage

// File: rtl/run_rate_div.sv
// Free-running rate divider: ticks when the count reaches 2**shift_i - 1.
// A >= compare is used so a shrinking period never skips a tick.
module run_rate_div #(
    parameter int unsigned DIV_W   = 20,
    parameter int unsigned SHIFT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic               tick_o
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] limit;

    // Terminal count and next divider value; clear has priority over counting.
    always_comb begin
        limit  = (DIV_W'(1) << shift_i) - DIV_W'(1);
        tick_o = (div_q >= limit);
        if (clr_i || tick_o) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/cybercobra_run_ctrl.sv
// Execution sequencer: turns step button, run switch and breakpoint into
// single-cycle core clock-enable pulses, and counts issued instructions.
module cybercobra_run_ctrl
    import cybercobra_ctrl_pkg::*;
#(
    parameter int unsigned MIN_SHIFT = 4,
    parameter int unsigned DIV_W     = 20,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  step_i,
    input  logic                  run_i,
    input  logic [RATE_SEL_W-1:0] rate_sel_i,
    input  logic                  bp_en_i,
    input  logic [31:0]           bp_addr_i,
    input  logic [31:0]           instr_addr_i,
    output logic                  core_en_o,
    output logic                  halted_o,
    output logic                  bp_hit_o,
    output logic [CNT_W-1:0]      instr_cnt_o
);

    localparam int unsigned SHIFT_W = $clog2(DIV_W);

    run_state_t       state_q, state_d;
    logic             step_q;
    logic             core_en_q, core_en_d;
    logic             halted_q, bp_hit_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_rise;
    logic             div_clr;
    logic             tick;
    logic [SHIFT_W-1:0] shift;

    assign shift = SHIFT_W'(rate_sel_i) + SHIFT_W'(MIN_SHIFT);

    run_rate_div #(
        .DIV_W   (DIV_W),
        .SHIFT_W (SHIFT_W)
    ) u_div (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (div_clr),
        .shift_i (shift),
        .tick_o  (tick)
    );

    // Next state, issue decision and divider clear.
    always_comb begin
        state_d   = state_q;
        core_en_d = 1'b0;
        div_clr   = 1'b0;
        step_rise = step_i & ~step_q;
        case (state_q)
            HALT: begin
                // Run switch wins over a simultaneous step.
                if (run_i) begin
                    state_d = RUN;
                    div_clr = 1'b1;
                end else if (step_rise) begin
                    core_en_d = 1'b1;
                end
            end
            RUN: begin
                if (!run_i) begin
                    state_d = HALT;
                end else if (tick) begin
                    if (bp_en_i && (instr_addr_i == bp_addr_i)) begin
                        state_d = BREAK;
                    end else begin
                        core_en_d = 1'b1;
                    end
                end
            end
            BREAK: begin
                // Resume pulse executes the breakpoint instruction unchecked.
                if (!run_i) begin
                    state_d = HALT;
                end else if (step_rise) begin
                    core_en_d = 1'b1;
                    state_d   = RUN;
                    div_clr   = 1'b1;
                end
            end
            default: state_d = HALT;
        endcase
        cnt_d = core_en_d ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // State, edge-detect, pulse and counter registers with registered status.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= HALT;
            step_q    <= 1'b1; // button held through reset must not step
            core_en_q <= 1'b0;
            cnt_q     <= '0;
            halted_q  <= 1'b1;
            bp_hit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_i;
            core_en_q <= core_en_d;
            cnt_q     <= cnt_d;
            halted_q  <= (state_d != RUN);
            bp_hit_q  <= (state_d == BREAK);
        end
    end

    assign core_en_o   = core_en_q;
    assign halted_o    = halted_q;
    assign bp_hit_o    = bp_hit_q;
    assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_cybercobra_run_ctrl.sv
// Directed bench for the CYBERcobra execution sequencer.
module tb_cybercobra_run_ctrl;

    logic        clk;
    logic        rst_i;
    logic        step_i;
    logic        run_i;
    logic [3:0]  rate_sel_i;
    logic        bp_en_i;
    logic [31:0] bp_addr_i;
    logic [31:0] pc;
    logic        core_en_o;
    logic        halted_o;
    logic        bp_hit_o;
    logic [31:0] instr_cnt_o;

    int n_vec  = 0;
    int n_err  = 0;
    int pulses = 0;
    int dbl    = 0;
    int p0     = 0;
    logic prev_en = 1'b0;
    logic pc_hold = 1'b1;

    cybercobra_run_ctrl #(
        .MIN_SHIFT (4),
        .DIV_W     (20),
        .CNT_W     (32)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .step_i       (step_i),
        .run_i        (run_i),
        .rate_sel_i   (rate_sel_i),
        .bp_en_i      (bp_en_i),
        .bp_addr_i    (bp_addr_i),
        .instr_addr_i (pc),
        .core_en_o    (core_en_o),
        .halted_o     (halted_o),
        .bp_hit_o     (bp_hit_o),
        .instr_cnt_o  (instr_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: sample at the falling edge, count pulses, advance the model PC.
    task automatic cyc();
        @(negedge clk);
        if (core_en_o && prev_en) dbl++;
        prev_en = core_en_o;
        if (core_en_o) begin
            pulses++;
            if (!pc_hold) pc = pc + 32'd4;
        end
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst_i = 1'b1; step_i = 1'b1; run_i = 1'b0; rate_sel_i = 4'd0;
        bp_en_i = 1'b0; bp_addr_i = 32'h0; pc = 32'h0;

        // 1: reset with step held
        cycn(3);
        rst_i = 1'b0;
        check("rst_core_en", {31'd0, core_en_o}, 32'd0);
        check("rst_halted", {31'd0, halted_o}, 32'd1);
        check("rst_bp_hit", {31'd0, bp_hit_o}, 32'd0);
        check("rst_cnt", instr_cnt_o, 32'd0);
        p0 = pulses;
        cycn(100);
        check("held_step_pulses", pulses - p0, 32'd0);
        check("held_step_halted", {31'd0, halted_o}, 32'd1);
        check("held_step_cnt", instr_cnt_o, 32'd0);

        // 2: three single steps
        step_i = 1'b0;
        cycn(2);
        for (int i = 0; i < 3; i++) begin
            step_i = 1'b1;
            cyc();
            check("step_pulse_hi", {31'd0, core_en_o}, 32'd1);
            cyc();
            check("step_pulse_lo", {31'd0, core_en_o}, 32'd0);
            cycn(3);
            step_i = 1'b0;
            cycn(45);
        end
        check("step_cnt", instr_cnt_o, 32'd3);

        // 3: free-run at 16-cycle period, stop on a tick cycle
        p0 = pulses;
        run_i = 1'b1;
        cycn(161);
        check("run_pulses_160", pulses - p0, 32'd10);
        check("run_cnt", instr_cnt_o, 32'd13);
        check("run_halted", {31'd0, halted_o}, 32'd0);
        cycn(15);
        run_i = 1'b0;
        cyc();
        check("stop_on_tick_en", {31'd0, core_en_o}, 32'd0);
        check("stop_on_tick_halted", {31'd0, halted_o}, 32'd1);
        check("stop_on_tick_cnt", instr_cnt_o, 32'd13);

        // 4: breakpoint at 0x0C with PC advancing by 4 per pulse
        pc = 32'h0; pc_hold = 1'b0; bp_en_i = 1'b1; bp_addr_i = 32'h0C;
        p0 = pulses;
        run_i = 1'b1;
        cycn(65);
        check("bp_pulses", pulses - p0, 32'd3);
        check("bp_hit", {31'd0, bp_hit_o}, 32'd1);
        check("bp_halted", {31'd0, halted_o}, 32'd1);
        check("bp_pc", pc, 32'h0C);
        p0 = pulses;
        step_i = 1'b1;
        cyc();
        check("resume_pulse", {31'd0, core_en_o}, 32'd1);
        check("resume_bp_hit", {31'd0, bp_hit_o}, 32'd0);
        check("resume_halted", {31'd0, halted_o}, 32'd0);
        step_i = 1'b0;
        cycn(16);
        check("after_resume_pulses", pulses - p0, 32'd2);
        check("no_rebreak_0x10", {31'd0, bp_hit_o}, 32'd0);
        check("after_resume_cnt", instr_cnt_o, 32'd18);
        run_i = 1'b0;
        cyc();

        // 5: jump-to-self at the breakpoint
        pc = 32'h0C; pc_hold = 1'b1;
        p0 = pulses;
        run_i = 1'b1;
        cycn(17);
        check("self_break", {31'd0, bp_hit_o}, 32'd1);
        check("self_break_pulses", pulses - p0, 32'd0);
        p0 = pulses;
        step_i = 1'b1;
        cyc();
        check("self_resume_pulse", {31'd0, core_en_o}, 32'd1);
        check("self_resume_bp_hit", {31'd0, bp_hit_o}, 32'd0);
        step_i = 1'b0;
        cycn(15);
        check("self_pre_tick", {31'd0, bp_hit_o}, 32'd0);
        cyc();
        check("self_rebreak", {31'd0, bp_hit_o}, 32'd1);
        check("self_one_pulse", pulses - p0, 32'd1);
        check("self_cnt", instr_cnt_o, 32'd19);
        run_i = 1'b0;
        cyc();

        // 6: rate shrink with count past the new limit, then reset mid-pulse
        bp_en_i = 1'b0; rate_sel_i = 4'd8;
        p0 = pulses;
        run_i = 1'b1;
        cycn(101);
        check("slow_no_pulse", pulses - p0, 32'd0);
        rate_sel_i = 4'd0;
        cyc();
        check("rate_change_tick", {31'd0, core_en_o}, 32'd1);
        check("rate_change_cnt", instr_cnt_o, 32'd20);
        rst_i = 1'b1;
        cyc();
        check("midrst_core_en", {31'd0, core_en_o}, 32'd0);
        check("midrst_halted", {31'd0, halted_o}, 32'd1);
        check("midrst_bp_hit", {31'd0, bp_hit_o}, 32'd0);
        check("midrst_cnt", instr_cnt_o, 32'd0);
        rst_i = 1'b0; run_i = 1'b0;
        cyc();

        check("pulse_width_1", dbl, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
